// File: rtl/hex_digits_renderer.sv
// hex_digits_renderer: scaled row of hex digits with frame-synchronous value commit.
// Optional cursor blink is enabled by defining HEX_BLINK_EN.
module hex_digits_renderer #(
    parameter int NDIGITS    = 4,
    parameter int SCALE_LOG2 = 1,
    parameter int X0         = 32,
    parameter int Y0         = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [8:0]           hpos,
    input  logic [8:0]           vpos,
    input  logic                 display_on,
    input  logic                 vsync,
    input  logic [4*NDIGITS-1:0] value,
    input  logic                 load,
    output logic                 pending,
`ifdef HEX_BLINK_EN
    input  logic [3:0]           cursor,
`endif
    output logic                 pixel_on
);
    localparam int S = SCALE_LOG2;
    localparam int W = NDIGITS * (8 << S);
    localparam int H = 8 << S;
    // 5x5 glyphs, rows 0..4 from the top, each row MSB = leftmost column
    localparam logic [24:0] FONT [16] = '{
        25'b11111_10001_10001_10001_11111, 25'b00100_01100_00100_00100_01110,
        25'b11111_00001_11111_10000_11111, 25'b11111_00001_01111_00001_11111,
        25'b10001_10001_11111_00001_00001, 25'b11111_10000_11111_00001_11111,
        25'b11111_10000_11111_10001_11111, 25'b11111_00001_00010_00100_00100,
        25'b11111_10001_11111_10001_11111, 25'b11111_10001_11111_00001_11111,
        25'b01110_10001_11111_10001_10001, 25'b11110_10001_11110_10001_11110,
        25'b01111_10000_10000_10000_01111, 25'b11110_10001_10001_10001_11110,
        25'b11111_10000_11110_10000_11111, 25'b11111_10000_11110_10000_10000
    };

    function automatic logic [7:0] digits16_array(input logic [3:0] digit, input logic [2:0] yofs);
        logic [4:0] pic;
        pic = yofs < 3'd5 ? 5'(FONT[digit] >> (5'd20 - 5'd5 * {2'b00, yofs})) : 5'd0;
        return {3'b000, pic[0], pic[1], pic[2], pic[3], pic[4]};
    endfunction

    logic [4*NDIGITS-1:0] pend_val, shown_val;
    logic                 vsync_d, commit, in_win, blank, pix;
    logic [9:0]           rx, ry;
    logic [3:0]           idx, nib;
    logic [2:0]           xoff, yoff;
    logic [7:0]           bits;

    assign commit = vsync & ~vsync_d;
    assign rx     = {1'b0, hpos} - 10'(X0);
    assign ry     = {1'b0, vpos} - 10'(Y0);
    assign in_win = {1'b0, hpos} >= 10'(X0) && {1'b0, hpos} < 10'(X0 + W) &&
                    {1'b0, vpos} >= 10'(Y0) && {1'b0, vpos} < 10'(Y0 + H);
    assign idx    = 4'(rx >> (3 + S));
    assign xoff   = 3'(rx >> S);
    assign yoff   = 3'(ry >> S);
    assign nib    = 4'(shown_val >> {4'(NDIGITS - 1) - idx, 2'b00});
    assign bits   = digits16_array(nib, yoff);
    assign pix    = display_on && in_win && xoff < 3'd5 && bits[xoff] && !blank;

`ifdef HEX_BLINK_EN
    logic [4:0] frame_cnt;
    assign blank = frame_cnt[4] && cursor == idx && {1'b0, cursor} < 5'(NDIGITS);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + 5'(commit);
`else
    assign blank = 1'b0;
`endif

    // A load coinciding with commit is staged for the following frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_val  <= '0;
            pending   <= 1'b0;
            shown_val <= '0;
            vsync_d   <= 1'b0;
            pixel_on  <= 1'b0;
        end else begin
            vsync_d  <= vsync;
            pixel_on <= pix;
            pending  <= load | (pending & ~commit);
            if (commit && pending)
                shown_val <= pend_val;
            if (load)
                pend_val <= value;
        end
    end
endmodule
